// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the serial system bus arbiter and the master-side mux.
//   GRANT_NONE / GRANT_M1 / GRANT_M2 : bus_grant encodings (mux compares these)
//   bus_state_e                      : arbiter FSM states
//   owner_e                          : round-robin "last owner" pointer values
//   grant_of()                       : bus_grant encoding for a given state
// -----------------------------------------------------------------------------
package bus_pkg;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M1   = 2'b01;
  localparam logic [1:0] GRANT_M2   = 2'b10;

  // State codes match the grant encodings so decode is trivial.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT1 = 2'b01,
    GNT2 = 2'b10
  } bus_state_e;

  typedef enum logic {
    OWNER_M1 = 1'b0,
    OWNER_M2 = 1'b1
  } owner_e;

  // Grant encoding driven while in a given state; unknown codes grant nobody.
  function automatic logic [1:0] grant_of(input bus_state_e state);
    logic [1:0] grant;
    case (state)
      GNT1:    grant = GRANT_M1;
      GNT2:    grant = GRANT_M2;
      IDLE:    grant = GRANT_NONE;
      default: grant = GRANT_NONE;
    endcase
    return grant;
  endfunction

endpackage

// File: rtl/bus_idle_watchdog.sv
// -----------------------------------------------------------------------------
// bus_idle_watchdog
// Saturating idle counter for the granted master. Counts enabled cycles,
// restarts on clear, and flags when the count has reached TIMEOUT-1 so the
// next idle edge is the TIMEOUT-th one.
//   clk     in  1  bus clock
//   rstn    in  1  synchronous active-low reset
//   clear   in  1  restart the count at zero (wins over enable)
//   enable  in  1  count one more idle cycle
//   expired out 1  registered: count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module bus_idle_watchdog #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [CNT_W-1:0] idle_cnt_r;
  logic [CNT_W-1:0] idle_cnt_inc_s;
  logic             expired_r;

  // Next count value when another idle cycle is counted.
  always_comb begin
    idle_cnt_inc_s = idle_cnt_r + CNT_ONE;
  end

  // Counter and expiry flag; the counter sticks at its maximum instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      idle_cnt_r <= {CNT_W{1'b0}};
      expired_r  <= 1'b0;
    end else if (clear) begin
      idle_cnt_r <= {CNT_W{1'b0}};
      expired_r  <= 1'b0;
    end else if (enable) begin
      if (idle_cnt_r != CNT_MAX) begin
        idle_cnt_r <= idle_cnt_inc_s;
        expired_r  <= (idle_cnt_inc_s >= LAST_IDLE);
      end else begin
        idle_cnt_r <= idle_cnt_r;
        expired_r  <= expired_r;
      end
    end else begin
      idle_cnt_r <= idle_cnt_r;
      expired_r  <= expired_r;
    end
  end

  assign expired = expired_r;

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Two-master round-robin arbiter for the serial system bus. A grant is held
// for the whole transaction (no preemption), every release passes through at
// least one IDLE cycle, and an idle watchdog revokes a grant whose owner
// keeps master_valid low for TIMEOUT consecutive granted edges.
//   clk             in  1  bus clock
//   rstn            in  1  synchronous active-low reset
//   m1_request      in  1  master 1 bus request (held for the transaction)
//   m2_request      in  1  master 2 bus request
//   m1_master_valid in  1  master 1 activity, feeds the watchdog
//   m2_master_valid in  1  master 2 activity, feeds the watchdog
//   bus_grant       out 2  00 none, 01 master 1, 10 master 2 (never 11)
//   m1_grant        out 1  bus_grant[0]
//   m2_grant        out 1  bus_grant[1]
//   bus_busy        out 1  bus_grant != 00
//   timeout         out 1  one-cycle pulse in the IDLE cycle after a revoke
// -----------------------------------------------------------------------------
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       m1_request,
  input  logic       m2_request,
  input  logic       m1_master_valid,
  input  logic       m2_master_valid,
  output logic [1:0] bus_grant,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic       bus_busy,
  output logic       timeout
);

  bus_state_e state_r;
  owner_e     last_r;
  logic [1:0] grant_r;
  logic       busy_r;
  logic       timeout_r;

  logic owner_req_s;
  logic owner_valid_s;
  logic wd_clear_s;
  logic wd_enable_s;
  logic wd_expired_s;

  // Route the current owner's request/valid; the other master is ignored.
  always_comb begin
    owner_req_s   = 1'b0;
    owner_valid_s = 1'b0;
    case (state_r)
      GNT1: begin
        owner_req_s   = m1_request;
        owner_valid_s = m1_master_valid;
      end
      GNT2: begin
        owner_req_s   = m2_request;
        owner_valid_s = m2_master_valid;
      end
      IDLE: begin
        owner_req_s   = 1'b0;
        owner_valid_s = 1'b0;
      end
      default: begin
        owner_req_s   = 1'b0;
        owner_valid_s = 1'b0;
      end
    endcase
  end

  // Count only while the grant is kept with an idle owner; every other case
  // (IDLE, activity, release, revoke) restarts the counter at zero, which
  // also covers the clear on grant entry since entry is always from IDLE.
  always_comb begin
    wd_enable_s = 1'b0;
    wd_clear_s  = 1'b1;
    if ((state_r != IDLE) && owner_req_s && !owner_valid_s && !wd_expired_s) begin
      wd_enable_s = 1'b1;
      wd_clear_s  = 1'b0;
    end else begin
      wd_enable_s = 1'b0;
      wd_clear_s  = 1'b1;
    end
  end

  bus_idle_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_idle_watchdog (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (wd_clear_s),
    .enable  (wd_enable_s),
    .expired (wd_expired_s)
  );

  // Arbitration FSM with round-robin pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r   <= IDLE;
      last_r    <= OWNER_M2;
      grant_r   <= GRANT_NONE;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // m1 wins if alone, or on contention when m2 owned the bus last.
          if (m1_request && (!m2_request || (last_r == OWNER_M2))) begin
            state_r <= GNT1;
            last_r  <= OWNER_M1;
            grant_r <= grant_of(GNT1);
            busy_r  <= 1'b1;
          end else if (m2_request) begin
            state_r <= GNT2;
            last_r  <= OWNER_M2;
            grant_r <= grant_of(GNT2);
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            last_r  <= last_r;
            grant_r <= GRANT_NONE;
            busy_r  <= 1'b0;
          end
        end
        GNT1, GNT2: begin
          // Release takes priority over a revoke on the same edge.
          if (!owner_req_s) begin
            state_r <= IDLE;
            grant_r <= GRANT_NONE;
            busy_r  <= 1'b0;
          end else if (wd_expired_s && !owner_valid_s) begin
            state_r   <= IDLE;
            grant_r   <= GRANT_NONE;
            busy_r    <= 1'b0;
            timeout_r <= 1'b1;
          end else begin
            state_r <= state_r;
            grant_r <= grant_of(state_r);
            busy_r  <= 1'b1;
          end
          last_r <= last_r;
        end
        default: begin
          state_r <= IDLE;
          last_r  <= last_r;
          grant_r <= GRANT_NONE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_grant = grant_r;
  assign m1_grant  = grant_r[0];
  assign m2_grant  = grant_r[1];
  assign bus_busy  = busy_r;
  assign timeout   = timeout_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Self-checking bench for bus_arbiter (TIMEOUT=4). A behavioural model tracks
// the bus owner, the round-robin winner and the run of idle granted edges;
// every cycle all outputs are compared against it. Directed scenarios cover
// reset, contention, hold, watchdog revoke/clear and mid-transaction reset,
// followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       m1_request, m2_request;
  logic       m1_master_valid, m2_master_valid;
  logic [1:0] bus_grant;
  logic       m1_grant, m2_grant, bus_busy, timeout;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: owner 0 = nobody, 1 = m1, 2 = m2.
  int own      = 0;
  int last     = 2;
  int idle_run = 0;
  bit to_flag  = 1'b0;

  bus_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .m1_request      (m1_request),
    .m2_request      (m2_request),
    .m1_master_valid (m1_master_valid),
    .m2_master_valid (m2_master_valid),
    .bus_grant       (bus_grant),
    .m1_grant        (m1_grant),
    .m2_grant        (m2_grant),
    .bus_busy        (bus_busy),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic model_edge();
    bit req, val;
    if (!rstn) begin
      own = 0; last = 2; idle_run = 0; to_flag = 1'b0;
      return;
    end
    to_flag = 1'b0;
    if (own == 0) begin
      if (m1_request && m2_request) own = (last == 1) ? 2 : 1;
      else if (m1_request)          own = 1;
      else if (m2_request)          own = 2;
      if (own != 0) begin
        last = own;
        idle_run = 0;
      end
    end else begin
      req = (own == 1) ? m1_request : m2_request;
      val = (own == 1) ? m1_master_valid : m2_master_valid;
      if (!req) begin
        own = 0;
      end else if (!val) begin
        idle_run++;
        if (idle_run >= TIMEOUT) begin
          own = 0;
          to_flag = 1'b1;
        end
      end else begin
        idle_run = 0;
      end
    end
  endtask

  // One clock: update model, let the edge pass, then compare every output.
  task automatic cycle();
    logic [1:0] exp_grant;
    model_edge();
    @(posedge clk);
    #1;
    exp_grant = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
    check("bus_grant", {6'd0, bus_grant}, {6'd0, exp_grant});
    check("m1_grant",  {7'd0, m1_grant},  {7'd0, exp_grant[0]});
    check("m2_grant",  {7'd0, m2_grant},  {7'd0, exp_grant[1]});
    check("bus_busy",  {7'd0, bus_busy},  {7'd0, (own != 0)});
    check("timeout",   {7'd0, timeout},   {7'd0, to_flag});
  endtask

  task automatic drive(input bit r1, input bit r2, input bit v1, input bit v2);
    m1_request = r1; m2_request = r2; m1_master_valid = v1; m2_master_valid = v2;
  endtask

  initial begin
    rstn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1;

    // Reset then single m2 request at cycle 5.
    cycle(); cycle();
    rstn = 1'b1;
    cycle(); cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    cycle();
    check("single_m2_grant", {6'd0, bus_grant}, 8'h02);
    check("single_m2_busy",  {7'd0, bus_busy},  8'h01);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(); cycle();

    // Contention straight out of reset: m1 first.
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    cycle();
    check("contend_first", {6'd0, bus_grant}, 8'h01);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    cycle();
    check("turnaround", {6'd0, bus_grant}, 8'h00);
    cycle();
    check("contend_second", {6'd0, bus_grant}, 8'h02);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    cycle();
    check("contend_third", {6'd0, bus_grant}, 8'h01);

    // Hold: m2 requests mid-transaction, m1 valid toggles; no preemption.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, i[0], 1'b1);
      cycle();
      check("hold_m1", {6'd0, bus_grant}, 8'h01);
    end

    // Watchdog revoke: m1 granted and idle for 4 edges.
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(); cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      cycle();
      check("wd_no_early", {7'd0, timeout}, 8'h00);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    cycle();
    check("wd_revoke_grant", {6'd0, bus_grant}, 8'h00);
    check("wd_revoke_pulse", {7'd0, timeout},   8'h01);
    cycle();
    check("wd_m2_wins", {6'd0, bus_grant}, 8'h02);
    check("wd_pulse_end", {7'd0, timeout}, 8'h00);

    // Watchdog clear: valid pulse on idle edge 3 restarts the count.
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(); cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle(); cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      cycle();
      check("wdc_still_granted", {6'd0, bus_grant}, 8'h01);
    end
    cycle();
    check("wdc_revoke", {7'd0, timeout}, 8'h01);

    // Mid-transaction reset during GNT2.
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(); cycle();
    check("pre_reset_gnt2", {6'd0, bus_grant}, 8'h02);
    rstn = 1'b0;
    cycle();
    check("rst_grant", {6'd0, bus_grant}, 8'h00);
    check("rst_busy",  {7'd0, bus_busy},  8'h00);
    check("rst_to",    {7'd0, timeout},   8'h00);
    rstn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    cycle();
    check("post_rst_rr", {6'd0, bus_grant}, 8'h01);

    // Randomized traffic with sticky requests and mostly-idle valids.
    for (int i = 0; i < 1500; i++) begin
      rstn = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 7) == 0) m1_request = ~m1_request;
      if ($urandom_range(0, 7) == 0) m2_request = ~m2_request;
      m1_master_valid = ($urandom_range(0, 9) < 4);
      m2_master_valid = ($urandom_range(0, 9) < 4);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
